d8_branch_unit: RTL
===================

# d8_branch_unit

Parametrised control-flow unit for the dumb8 core. It decodes jump, conditional jump, call and return opcodes against the Z/C/N flags and drives the instruction-fetch redirect (`mem_addr`, `load`) and the decode-pipeline flush (`li_di_rst`). It keeps a hardware return-address stack of configurable depth. It sits between the decode stage and the program memory address mux. Unlike a purely combinational jump decoder, it registers its redirect, holds call/return state, and flags stack faults.

## Interface
- `AW`, default 8: program address width.
- `DEPTH`, default 4: number of return-stack entries (≥1).
- `SPW`, default `$clog2(DEPTH+1)`: width of the stack-pointer and depth count.
- `sys_clk`  in  1: clock, rising-edge.
- `sys_rst`  in  1: reset, asynchronous, active-high.
- `op_valid`  in  1: `op`/`a` carry a decoded instruction this cycle.
- `op`  in  8: opcode.
- `a`  in  AW: branch target operand.
- `ret_addr`  in  AW: address of the instruction after the current one (pushed by CALL).
- `z`, `c`, `n`  in  1 each: ALU flags, valid with `op_valid`.
- `li_di_rst`  out  1: pipeline flush, registered.
- `mem_addr`  out  AW: redirect address, registered.
- `load`  out  1: fetch-PC load strobe, registered.
- `depth`  out  SPW: current number of stacked entries.
- `ovf`  out  1: sticky flag for CALL-on-full.
- `unf`  out  1: sticky flag for RET-on-empty.

## Operation
- Opcodes and their taken condition:
  - 0x09 JMP: always.
  - 0x0a JZ: z=1.
  - 0x0b JNZ: z=0.
  - 0x0c JC: c=1.
  - 0x0d JN: n=1.
  - 0x0e CALL: always, unless the stack is full.
  - 0x0f RET: always, unless the stack is empty.
  - Any other opcode: never taken; the unit does nothing.
- Evaluation happens on a `sys_clk` rising edge with `op_valid`=1 and `load`=0. When `load`=1 (flush cycle), `op_valid` is ignored entirely: no redirect, no stack change, no fault.
- Taken JMP/Jcc/CALL: next cycle `mem_addr`=`a`, `load`=1, `li_di_rst`=1.
- Taken RET: next cycle `mem_addr`=top-of-stack entry, `load`=1, `li_di_rst`=1.
- Not taken: next cycle `load`=0, `li_di_rst`=0, `mem_addr`=0.
- Return stack: LIFO of DEPTH×AW registers. Stack pointer `sp` runs 0..DEPTH and `depth`=`sp`.
  - CALL with `sp`<DEPTH: write `ret_addr` at index `sp`, then `sp`+1.
  - RET with `sp`>0: read index `sp`-1, then `sp`-1.
- CALL with `sp`=DEPTH: not taken, no push, `ovf` set.
- RET with `sp`=0: not taken, no pop, `unf` set.
- `ovf`/`unf` clear only on reset.
- Stack entries are not cleared on reset; only `sp` is. Contents at or above `sp` are don't-care.

## Timing
- Latency is exactly 1 cycle from the sampling edge to the redirect outputs. Stack and `depth` update on the same sampling edge.
- `load` and `li_di_rst` are single-cycle pulses: high for exactly one cycle per taken branch, never two consecutive cycles.
- Reset values:
  - `li_di_rst`=1, so the pipeline is held flushed during reset.
  - `load`=0, `mem_addr`=0, `depth`=0, `ovf`=0, `unf`=0.
- On the first edge after reset deasserts, `li_di_rst` falls to 0 (no valid branch can be evaluated on that edge).
- Reset asserted mid-operation (including during a `load` pulse) forces the reset values immediately and asynchronously. Any pending push/pop is lost.
- Back-to-back branches: a branch arriving in the `load` cycle is dropped by rule. The core re-fetches, so the earliest next evaluation is 2 cycles after the previous one.
- `depth` is valid combinationally from registers (no extra latency). Flags are sampled only on the evaluation edge.

## Test plan
- Reset: hold `sys_rst`=1 → `li_di_rst`=1, `load`=0, `mem_addr`=0, `depth`=0. Release it → `li_di_rst`=0 one edge later.
- Conditional decode: JZ a=0x3C with z=0 → no `load`; then JZ a=0x3C with z=1 → `load`=1, `mem_addr`=0x3C, `li_di_rst`=1 for exactly one cycle. Repeat for JNZ, JC and JN with both flag polarities.
- Call/return nesting (DEPTH=4):
  - CALLs to 0x10, 0x20, 0x30 with `ret_addr` 0x05, 0x11, 0x21 → `depth`=3.
  - Three RETs → `mem_addr` 0x21, 0x11, 0x05 in order, `depth`=0.
- Overflow/underflow:
  - 5th CALL at `depth`=4 → no `load`, `ovf`=1, `depth` stays 4.
  - RET at `depth`=0 → no `load`, `unf`=1.
  - Both flags hold until reset.
- Flush-cycle rule: JMP 0x40 then, in its `load` cycle, CALL 0x50 with `op_valid`=1 → only 0x40 redirect, `depth` unchanged.
- Async reset mid-call: assert `sys_rst` between clock edges right after a CALL edge → outputs go to reset values without waiting for a clock edge; `depth`=0. Repeat with AW=12, DEPTH=1.

Source files
------------

// File: rtl/d8_branch_unit.sv
// Control-flow unit for the dumb8 core: decodes jumps, calls and returns,
// drives a registered fetch redirect and keeps a hardware return-address stack.
module d8_branch_unit #(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           op_valid,
  input  logic [7:0]     op,
  input  logic [AW-1:0]  a,
  input  logic [AW-1:0]  ret_addr,
  input  logic           z,
  input  logic           c,
  input  logic           n,
  output logic           li_di_rst,
  output logic [AW-1:0]  mem_addr,
  output logic           load,
  output logic [SPW-1:0] depth,
  output logic           ovf,
  output logic           unf
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [7:0] OP_JMP  = 8'h09;
  localparam logic [7:0] OP_JZ   = 8'h0a;
  localparam logic [7:0] OP_JNZ  = 8'h0b;
  localparam logic [7:0] OP_JC   = 8'h0c;
  localparam logic [7:0] OP_JN   = 8'h0d;
  localparam logic [7:0] OP_CALL = 8'h0e;
  localparam logic [7:0] OP_RET  = 8'h0f;

  logic [AW-1:0]  stack [DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_m1;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;
  logic           eval;
  logic           cond;
  logic           is_call;
  logic           is_ret;
  logic           full;
  logic           empty;
  logic           taken;
  logic           push;
  logic           pop;
  logic [AW-1:0]  target;

  // op_valid qualifies op/a/ret_addr/flags for one cycle; there is no ready:
  // an instruction presented while load is high (flush cycle) is dropped.
  assign eval   = op_valid & ~load;
  assign full   = (sp == SPW'(DEPTH));
  assign empty  = (sp == '0);
  assign sp_m1  = sp - SPW'(1);
  assign wr_idx = sp[IW-1:0];
  assign rd_idx = sp_m1[IW-1:0];
  assign depth  = sp;

  always_comb begin
    cond    = 1'b0;
    is_call = 1'b0;
    is_ret  = 1'b0;
    case (op)
      OP_JMP:  cond = 1'b1;
      OP_JZ:   cond = z;
      OP_JNZ:  cond = ~z;
      OP_JC:   cond = c;
      OP_JN:   cond = n;
      OP_CALL: begin
        is_call = 1'b1;
        cond    = ~full;
      end
      OP_RET:  begin
        is_ret = 1'b1;
        cond   = ~empty;
      end
      default: cond = 1'b0;
    endcase
  end

  assign taken  = eval & cond;
  assign push   = taken & is_call;
  assign pop    = taken & is_ret;
  assign target = pop ? stack[rd_idx] : a;

  // Stack contents are deliberately not reset; only sp defines validity.
  always_ff @(posedge sys_clk) begin
    if (push) stack[wr_idx] <= ret_addr;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sp        <= '0;
      li_di_rst <= 1'b1;
      load      <= 1'b0;
      mem_addr  <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      if (push)     sp <= sp + SPW'(1);
      else if (pop) sp <= sp_m1;
      li_di_rst <= taken;
      load      <= taken;
      mem_addr  <= taken ? target : '0;
      if (eval && is_call && full) ovf <= 1'b1;
      if (eval && is_ret && empty) unf <= 1'b1;
    end
  end

endmodule
